// File: rtl/regfile_pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pc_unit_if
//  Description : Bundles the fetch, decode and writeback signals of
//                regfile_pc_unit.
//                master : pipeline side (drives requests, receives pc/rdata)
//                slave  : regfile_pc_unit itself
//                Fetch     : pcread, pcpred, pcenable, next_pc -> pc, redirected
//                Decode    : rfmode, rreg, claim, cfmode, creg -> rdata, rbusy
//                Writeback : wenable, wfmode, wreg, wdata
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_pc_unit_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 3
);
    localparam int AW = $clog2(NREG);

    logic                pcread;
    logic [XLEN-1:0]     pcpred;
    logic                pcenable;
    logic [XLEN-1:0]     next_pc;
    logic [XLEN-1:0]     pc;
    logic                redirected;
    logic [NRD-1:0]      rfmode;
    logic [NRD*AW-1:0]   rreg;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                claim;
    logic                cfmode;
    logic [AW-1:0]       creg;
    logic                wenable;
    logic                wfmode;
    logic [AW-1:0]       wreg;
    logic [XLEN-1:0]     wdata;

    modport master (
        output pcread, pcpred, pcenable, next_pc,
        output rfmode, rreg, claim, cfmode, creg,
        output wenable, wfmode, wreg, wdata,
        input  pc, redirected, rdata, rbusy
    );

    modport slave (
        input  pcread, pcpred, pcenable, next_pc,
        input  rfmode, rreg, claim, cfmode, creg,
        input  wenable, wfmode, wreg, wdata,
        output pc, redirected, rdata, rbusy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pc_unit
//  Description : Architectural state of the core: PC sequencer with a short
//                fetch history used to drop redirects onto an already-fetched
//                path, plus integer and float register files with NRD
//                registered read ports, one write port, write->read bypass
//                and a per-register busy scoreboard.
//  Ports       : clk  - clock, all state updates on posedge
//                rstn - synchronous active-low reset
//                bus  - regfile_pc_unit_if.slave (fetch/decode/writeback)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_pc_unit #(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter int              NRD      = 3,
    parameter int              HIST     = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              BYPASS   = 1
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    regfile_pc_unit_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    // Both files live in one array; the file select is the index MSB, so
    // flat index 0 is integer register 0.
    logic [XLEN-1:0]     pc_q, pc_d;
    logic                redirected_q, redirected_d;
    logic [XLEN-1:0]     hist_q [HIST];
    logic [XLEN-1:0]     hist_d [HIST];
    logic [HIST-1:0]     hist_v_q, hist_v_d;
    logic [2*NREG-1:0]   busy_q, busy_d;
    logic [XLEN-1:0]     rf_q [2*NREG];
    logic [NRD*XLEN-1:0] rdata_q, rdata_d;
    logic [NRD-1:0]      rbusy_q, rbusy_d;

    logic [AW:0]         w_widx;
    logic [AW:0]         w_cidx;
    logic                w_wr_en;
    logic                w_claim_en;
    logic                w_suppress;

    assign w_widx     = {bus.wfmode, bus.wreg};
    assign w_cidx     = {bus.cfmode, bus.creg};
    assign w_wr_en    = rstn && bus.wenable && (w_widx != '0);
    assign w_claim_en = rstn && bus.claim && (w_cidx != '0);
    // Only a valid oldest entry can filter; an empty history never matches.
    assign w_suppress = hist_v_q[HIST-1] && (hist_q[HIST-1] == bus.next_pc);

    // PC sequencer: redirect beats sequential advance beats hold.
    always_comb begin
        pc_d         = pc_q;
        hist_d       = hist_q;
        hist_v_d     = hist_v_q;
        redirected_d = 1'b0;
        if (!rstn) begin
            pc_d     = RESET_PC;
            hist_v_d = '0;
        end else if (bus.pcenable && !w_suppress) begin
            pc_d         = bus.next_pc;
            hist_v_d     = '0;
            redirected_d = 1'b1;
        end else if (bus.pcread) begin
            pc_d        = bus.pcpred + XLEN'(4);
            hist_d[0]   = bus.pcpred;
            hist_v_d[0] = 1'b1;
            for (int k = 1; k < HIST; k++) begin
                hist_d[k]   = hist_q[k-1];
                hist_v_d[k] = hist_v_q[k-1];
            end
        end
    end

    // Scoreboard: a write clears busy, a claim in the same cycle sets it again.
    always_comb begin
        busy_d = busy_q;
        if (!rstn) begin
            busy_d = '0;
        end else begin
            if (w_wr_en)    busy_d[w_widx] = 1'b0;
            if (w_claim_en) busy_d[w_cidx] = 1'b1;
        end
    end

    // Read ports: bypassed ports see this cycle's write data and busy update.
    always_comb begin
        logic [AW:0] idx;
        idx     = '0;
        rdata_d = '0;
        rbusy_d = '0;
        if (rstn) begin
            for (int i = 0; i < NRD; i++) begin
                idx = {bus.rfmode[i], bus.rreg[i*AW +: AW]};
                if (idx != '0) begin
                    if ((BYPASS != 0) && w_wr_en && (w_widx == idx))
                        rdata_d[i*XLEN +: XLEN] = bus.wdata;
                    else
                        rdata_d[i*XLEN +: XLEN] = rf_q[idx];
                    rbusy_d[i] = (BYPASS != 0) ? busy_d[idx] : busy_q[idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        pc_q         <= pc_d;
        redirected_q <= redirected_d;
        hist_q       <= hist_d;
        hist_v_q     <= hist_v_d;
        busy_q       <= busy_d;
        rdata_q      <= rdata_d;
        rbusy_q      <= rbusy_d;
    end

    // Register contents are not reset; integer reg 0 is never stored or read.
    always_ff @(posedge clk) begin
        if (w_wr_en) rf_q[w_widx] <= bus.wdata;
    end

    assign bus.pc         = pc_q;
    assign bus.redirected = redirected_q;
    assign bus.rdata      = rdata_q;
    assign bus.rbusy      = rbusy_q;
endmodule
`default_nettype wire

// File: tb/tb_regfile_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_pc_unit
//  Description : Self-checking bench for regfile_pc_unit. A BYPASS=1 and a
//                BYPASS=0 instance see identical stimulus: a directed table
//                of cycles, then randomized traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_pc_unit;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 3;
    localparam int HIST = 2;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    regfile_pc_unit_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus0 ();
    regfile_pc_unit_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus1 ();

    regfile_pc_unit #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .HIST(HIST),
                      .RESET_PC('0), .BYPASS(1))
        dut0 (.clk(clk), .rstn(rstn), .bus(bus0));
    regfile_pc_unit #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .HIST(HIST),
                      .RESET_PC('0), .BYPASS(0))
        dut1 (.clk(clk), .rstn(rstn), .bus(bus1));

    assign bus1.pcread   = bus0.pcread;
    assign bus1.pcpred   = bus0.pcpred;
    assign bus1.pcenable = bus0.pcenable;
    assign bus1.next_pc  = bus0.next_pc;
    assign bus1.rfmode   = bus0.rfmode;
    assign bus1.rreg     = bus0.rreg;
    assign bus1.claim    = bus0.claim;
    assign bus1.cfmode   = bus0.cfmode;
    assign bus1.creg     = bus0.creg;
    assign bus1.wenable  = bus0.wenable;
    assign bus1.wfmode   = bus0.wfmode;
    assign bus1.wreg     = bus0.wreg;
    assign bus1.wdata    = bus0.wdata;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rstn;
        logic        pcread;
        logic [31:0] pcpred;
        logic        pcenable;
        logic [31:0] npc;
        logic        wen;
        logic        wf;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        claim;
        logic        cf;
        logic [4:0]  creg;
        logic        rf0;
        logic [4:0]  rreg0;
        logic [31:0] e_pc;
        logic        e_red;
        logic        chk_d;
        logic [31:0] e_d;
        logic        chk_nb;
        logic [31:0] e_nb;
        logic        chk_b;
        logic        e_b;
    } row_t;

    row_t tbl[$];

    function automatic row_t idle_row();
        row_t v;
        v = '{rstn:1'b1, pcread:1'b0, pcpred:32'h0, pcenable:1'b0, npc:32'h0,
              wen:1'b0, wf:1'b0, wreg:5'd0, wdata:32'h0, claim:1'b0, cf:1'b0,
              creg:5'd0, rf0:1'b0, rreg0:5'd0, e_pc:32'h0, e_red:1'b0,
              chk_d:1'b0, e_d:32'h0, chk_nb:1'b0, e_nb:32'h0, chk_b:1'b0, e_b:1'b0};
        return v;
    endfunction

    task automatic build_table();
        row_t v;
        v = idle_row(); v.rstn = 0; v.pcenable = 1; v.npc = 32'h40;
        v.chk_d = 1; v.chk_nb = 1; v.chk_b = 1;                        tbl.push_back(v);
        v = idle_row(); v.chk_d = 1; v.chk_nb = 1; v.chk_b = 1;        tbl.push_back(v);
        v = idle_row(); v.pcread = 1; v.pcpred = 32'h100; v.e_pc = 32'h104; tbl.push_back(v);
        v = idle_row(); v.pcread = 1; v.pcpred = 32'h104; v.e_pc = 32'h108; tbl.push_back(v);
        v = idle_row(); v.pcenable = 1; v.npc = 32'h100; v.e_pc = 32'h108;  tbl.push_back(v);
        v = idle_row(); v.pcenable = 1; v.npc = 32'h200; v.e_pc = 32'h200; v.e_red = 1; tbl.push_back(v);
        v = idle_row(); v.e_pc = 32'h200;                                   tbl.push_back(v);
        v = idle_row(); v.pcenable = 1; v.npc = 32'h100; v.e_pc = 32'h100; v.e_red = 1; tbl.push_back(v);
        v = idle_row(); v.pcenable = 1; v.npc = 32'hFFFFFFFF; v.e_pc = 32'hFFFFFFFF; v.e_red = 1; tbl.push_back(v);
        v = idle_row(); v.pcread = 1; v.pcpred = 32'hFFFFFFFC; v.e_pc = 32'h0; tbl.push_back(v);
        v = idle_row(); v.wen = 1; v.wreg = 5; v.wdata = 32'h11111111; v.rreg0 = 5;
        v.chk_d = 1; v.e_d = 32'h11111111;                              tbl.push_back(v);
        v = idle_row(); v.wen = 1; v.wreg = 5; v.wdata = 32'hDEADBEEF; v.rreg0 = 5;
        v.chk_d = 1; v.e_d = 32'hDEADBEEF; v.chk_nb = 1; v.e_nb = 32'h11111111; tbl.push_back(v);
        v = idle_row(); v.rreg0 = 5; v.chk_d = 1; v.e_d = 32'hDEADBEEF;
        v.chk_nb = 1; v.e_nb = 32'hDEADBEEF;                            tbl.push_back(v);
        v = idle_row(); v.wen = 1; v.wreg = 0; v.wdata = 32'h1234;
        v.chk_d = 1; v.chk_nb = 1;                                      tbl.push_back(v);
        v = idle_row(); v.chk_d = 1; v.chk_nb = 1; v.chk_b = 1;         tbl.push_back(v);
        v = idle_row(); v.wen = 1; v.wf = 1; v.wreg = 0; v.wdata = 32'h1234; v.rf0 = 1;
        v.chk_d = 1; v.e_d = 32'h1234;                                  tbl.push_back(v);
        v = idle_row(); v.rf0 = 1; v.chk_d = 1; v.e_d = 32'h1234;
        v.chk_nb = 1; v.e_nb = 32'h1234;                                tbl.push_back(v);
        v = idle_row(); v.claim = 1; v.creg = 7; v.rreg0 = 7; v.chk_b = 1; v.e_b = 1; tbl.push_back(v);
        v = idle_row(); v.rreg0 = 7; v.chk_b = 1; v.e_b = 1;            tbl.push_back(v);
        v = idle_row(); v.claim = 1; v.creg = 7; v.wen = 1; v.wreg = 7; v.wdata = 32'h77;
        v.rreg0 = 7; v.chk_d = 1; v.e_d = 32'h77; v.chk_b = 1; v.e_b = 1; tbl.push_back(v);
        v = idle_row(); v.rreg0 = 7; v.chk_d = 1; v.e_d = 32'h77; v.chk_nb = 1; v.e_nb = 32'h77;
        v.chk_b = 1; v.e_b = 1;                                         tbl.push_back(v);
        v = idle_row(); v.wen = 1; v.wreg = 7; v.wdata = 32'h78; v.rreg0 = 7;
        v.chk_d = 1; v.e_d = 32'h78; v.chk_nb = 1; v.e_nb = 32'h77; v.chk_b = 1; v.e_b = 0; tbl.push_back(v);
        v = idle_row(); v.claim = 1; v.creg = 0; v.pcread = 1; v.pcpred = 32'h300; v.e_pc = 32'h304;
        v.chk_d = 1; v.chk_b = 1;                                       tbl.push_back(v);
        v = idle_row(); v.rstn = 0; v.pcenable = 1; v.npc = 32'h500; v.wen = 1; v.wreg = 7;
        v.wdata = 32'h99; v.claim = 1; v.creg = 7; v.rreg0 = 7;
        v.chk_d = 1; v.chk_nb = 1; v.chk_b = 1;                         tbl.push_back(v);
        v = idle_row(); v.rreg0 = 7; v.chk_d = 1; v.e_d = 32'h78; v.chk_nb = 1; v.e_nb = 32'h78;
        v.chk_b = 1; v.e_b = 0;                                         tbl.push_back(v);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_rf   [2*NREG];
    bit          m_busy [2*NREG];
    logic [31:0] m_hist [$];
    logic [31:0] m_pc;
    logic [31:0] e_pc;
    logic        e_red;
    logic [31:0] e_rd [NRD];
    logic [31:0] e_rd_nb [NRD];
    logic        e_rb [NRD];
    logic        e_rb_nb [NRD];

    // Predicts the outputs after the coming posedge from the inputs now on bus0.
    task automatic model_step();
        int  widx, cidx, idx;
        bit  wv, cv, sup;
        bit  nbusy [2*NREG];
        widx = {bus0.wfmode, bus0.wreg};
        cidx = {bus0.cfmode, bus0.creg};
        if (!rstn) begin
            m_pc = 32'h0;
            m_hist.delete();
            foreach (m_busy[j]) m_busy[j] = 1'b0;
            e_red = 1'b0;
            for (int i = 0; i < NRD; i++) begin
                e_rd[i] = 0; e_rd_nb[i] = 0; e_rb[i] = 0; e_rb_nb[i] = 0;
            end
        end else begin
            sup = (m_hist.size() == HIST) && (m_hist[HIST-1] == bus0.next_pc);
            e_red = 1'b0;
            if (bus0.pcenable && !sup) begin
                m_pc = bus0.next_pc;
                m_hist.delete();
                e_red = 1'b1;
            end else if (bus0.pcread) begin
                m_pc = bus0.pcpred + 32'd4;
                m_hist.push_front(bus0.pcpred);
                if (m_hist.size() > HIST) void'(m_hist.pop_back());
            end
            wv = bus0.wenable && (widx != 0);
            cv = bus0.claim && (cidx != 0);
            nbusy = m_busy;
            if (wv) nbusy[widx] = 1'b0;
            if (cv) nbusy[cidx] = 1'b1;
            for (int i = 0; i < NRD; i++) begin
                idx = {bus0.rfmode[i], bus0.rreg[i*AW +: AW]};
                if (idx == 0) begin
                    e_rd[i] = 0; e_rd_nb[i] = 0; e_rb[i] = 0; e_rb_nb[i] = 0;
                end else begin
                    e_rd_nb[i] = m_rf[idx];
                    e_rd[i]    = (wv && widx == idx) ? bus0.wdata : m_rf[idx];
                    e_rb[i]    = nbusy[idx];
                    e_rb_nb[i] = m_busy[idx];
                end
            end
            if (wv) m_rf[widx] = bus0.wdata;
            m_busy = nbusy;
        end
        e_pc = m_pc;
    endtask

    task automatic check_model();
        check("pc", bus0.pc, e_pc);
        check("redirected", bus0.redirected, e_red);
        for (int i = 0; i < NRD; i++) begin
            check($sformatf("rdata%0d", i), bus0.rdata[i*XLEN +: XLEN], e_rd[i]);
            check($sformatf("rbusy%0d", i), bus0.rbusy[i], e_rb[i]);
            check($sformatf("nb_rdata%0d", i), bus1.rdata[i*XLEN +: XLEN], e_rd_nb[i]);
            check($sformatf("nb_rbusy%0d", i), bus1.rbusy[i], e_rb_nb[i]);
        end
    endtask

    task automatic drive_idle();
        rstn = 1'b1;
        bus0.pcread = 0; bus0.pcpred = 0; bus0.pcenable = 0; bus0.next_pc = 0;
        bus0.rfmode = 0; bus0.rreg = 0; bus0.claim = 0; bus0.cfmode = 0; bus0.creg = 0;
        bus0.wenable = 0; bus0.wfmode = 0; bus0.wreg = 0; bus0.wdata = 0;
    endtask

    initial begin
        row_t r;
        drive_idle();
        build_table();

        // Directed table: one row per cycle, outputs sampled 1 time unit after the edge.
        for (int n = 0; n < tbl.size(); n++) begin
            r = tbl[n];
            drive_idle();
            rstn          = r.rstn;
            bus0.pcread   = r.pcread;  bus0.pcpred  = r.pcpred;
            bus0.pcenable = r.pcenable; bus0.next_pc = r.npc;
            bus0.wenable  = r.wen;     bus0.wfmode  = r.wf;
            bus0.wreg     = r.wreg;    bus0.wdata   = r.wdata;
            bus0.claim    = r.claim;   bus0.cfmode  = r.cf;  bus0.creg = r.creg;
            bus0.rfmode   = {2'b00, r.rf0};
            bus0.rreg     = {10'd0, r.rreg0};
            @(posedge clk); #1;
            check($sformatf("row%0d pc", n), bus0.pc, r.e_pc);
            check($sformatf("row%0d redirected", n), bus0.redirected, r.e_red);
            if (r.chk_d)  check($sformatf("row%0d rdata0", n), bus0.rdata[31:0], r.e_d);
            if (r.chk_nb) check($sformatf("row%0d nb_rdata0", n), bus1.rdata[31:0], r.e_nb);
            if (r.chk_b)  check($sformatf("row%0d rbusy0", n), bus0.rbusy[0], r.e_b);
        end

        // Re-synchronise with the model: reset, then fill every register.
        drive_idle();
        rstn = 1'b0;
        model_step(); @(posedge clk); #1; check_model();
        for (int idx = 0; idx < 2*NREG; idx++) begin
            drive_idle();
            bus0.wenable = 1;
            bus0.wfmode  = idx[5];
            bus0.wreg    = idx[4:0];
            bus0.wdata   = $urandom;
            model_step(); @(posedge clk); #1; check_model();
        end

        // Randomised traffic, biased towards small indices and a small PC set
        // so collisions, bypasses and history matches happen often.
        for (int n = 0; n < 1500; n++) begin
            rstn          = ($urandom_range(0, 49) != 0);
            bus0.pcread   = $urandom_range(0, 1);
            bus0.pcpred   = 32'h100 + 32'($urandom_range(0, 3)) * 4;
            bus0.pcenable = ($urandom_range(0, 2) == 0);
            bus0.next_pc  = ($urandom_range(0, 3) == 0) ? $urandom
                                                        : 32'h100 + 32'($urandom_range(0, 3)) * 4;
            bus0.rfmode   = 3'($urandom);
            for (int i = 0; i < NRD; i++)
                bus0.rreg[i*AW +: AW] = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            bus0.wenable  = $urandom_range(0, 1);
            bus0.wfmode   = $urandom_range(0, 1);
            bus0.wreg     = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            bus0.wdata    = $urandom;
            bus0.claim    = ($urandom_range(0, 2) == 0);
            bus0.cfmode   = $urandom_range(0, 1);
            bus0.creg     = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            model_step(); @(posedge clk); #1; check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
